// File: rtl/nzcv_flag_unit_pkg.sv
// Shared definitions for the NZCV flag holder and the condition tester:
// flag bit positions, flag-unit state encoding and ARM-style condition codes.
package nzcv_flag_unit_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } flag_state_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Evaluates a condition code against a set of flags; used by the condition tester.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/nzcv_flag_unit_timer.sv
// Multiply-latency counter: loaded with MUL_LAT at issue, counts down while
// the flag unit waits, and flags the final pending cycle.
module mul_flag_timer #(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic abort_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Abort clears the count, issue loads the full latency, otherwise count down while running.
    always_comb begin
        cnt_d = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(MUL_LAT);
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/nzcv_flag_unit.sv
// Architectural NZCV flag holder: commits ALU and delayed multiplier flags,
// forwards in-flight ALU flags to decode, stalls decode while multiply flags
// are outstanding, and keeps a shadow copy for exception entry/return.
module nzcv_flag_unit
    import nzcv_flag_unit_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  logic       ex_s_bit,
    input  logic       ex_is_mul,
    input  logic [3:0] alu_flags,
    input  logic [3:0] mul_flags,
    input  logic       id_needs_flags,
    input  logic       id_sets_flags,
    input  logic       exc_entry,
    input  logic       exc_return,
    output logic [3:0] flags_out,
    output logic [3:0] saved_flags,
    output logic       mul_pending,
    output logic       flag_stall
);

    flag_state_e state_q;
    flag_state_e state_d;
    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic [3:0]  saved_q;
    logic [3:0]  saved_d;
    logic        alu_wr;
    logic        mul_iss;
    logic        timer_load;
    logic        timer_abort;
    logic        timer_expire;
    logic        in_pend;

    assign alu_wr  = ex_valid & ex_s_bit & ~ex_is_mul;
    assign mul_iss = ex_valid & ex_s_bit & ex_is_mul;
    assign in_pend = (state_q == ST_PEND);

    mul_flag_timer #(
        .MUL_LAT (MUL_LAT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .abort_i  (timer_abort),
        .run_i    (in_pend),
        .expire_o (timer_expire)
    );

    // Prioritised flag update: exception entry, exception return, multiply commit, then ALU/issue.
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        saved_d     = saved_q;
        timer_load  = 1'b0;
        timer_abort = 1'b0;
        if (exc_entry) begin
            saved_d     = flags_q;
            state_d     = ST_IDLE;
            timer_abort = 1'b1;
        end else begin
            if (state_q == ST_PEND) begin
                if (timer_expire) begin
                    flags_d = mul_flags;
                    state_d = ST_IDLE;
                end
            end else if (!exc_return) begin
                if (alu_wr) begin
                    flags_d = alu_flags;
                end
                if (mul_iss) begin
                    state_d    = ST_PEND;
                    timer_load = 1'b1;
                end
            end
            if (exc_return) begin
                flags_d = saved_q;
            end
        end
    end

    // State, live flags and shadow flags, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            flags_q <= 4'b0000;
            saved_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            saved_q <= saved_d;
        end
    end

    // Same-cycle forwarding of ALU flags to the condition tester, forced to zero in reset.
    always_comb begin
        flags_out = flags_q;
        if (reset) begin
            flags_out = 4'b0000;
        end else if ((state_q == ST_IDLE) && alu_wr) begin
            flags_out = alu_flags;
        end
    end

    assign saved_flags = saved_q;
    assign mul_pending = in_pend;
    assign flag_stall  = in_pend & (id_needs_flags | id_sets_flags);

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Self-checking bench for nzcv_flag_unit with MUL_LAT=3: a vector table of
// per-cycle inputs and expected outputs, plus hand-written reset sequences.
module tb_nzcv_flag_unit;

    logic       clk;
    logic       reset;
    logic       ex_valid;
    logic       ex_s_bit;
    logic       ex_is_mul;
    logic [3:0] alu_flags;
    logic [3:0] mul_flags;
    logic       id_needs_flags;
    logic       id_sets_flags;
    logic       exc_entry;
    logic       exc_return;
    logic [3:0] flags_out;
    logic [3:0] saved_flags;
    logic       mul_pending;
    logic       flag_stall;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic       v;
        logic       s;
        logic       m;
        logic [3:0] alu;
        logic [3:0] mulf;
        logic       needs;
        logic       sets;
        logic       entry;
        logic       ret;
        logic       chkOut;
        logic [3:0] expOut;
        logic [3:0] expSaved;
        logic       expPend;
        logic       expStall;
    } vec_t;

    typedef struct {
        string      name;
        logic       chkOut;
        logic [3:0] out;
        logic [3:0] saved;
        logic       pend;
        logic       stall;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    nzcv_flag_unit #(
        .MUL_LAT (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_s_bit       (ex_s_bit),
        .ex_is_mul      (ex_is_mul),
        .alu_flags      (alu_flags),
        .mul_flags      (mul_flags),
        .id_needs_flags (id_needs_flags),
        .id_sets_flags  (id_sets_flags),
        .exc_entry      (exc_entry),
        .exc_return     (exc_return),
        .flags_out      (flags_out),
        .saved_flags    (saved_flags),
        .mul_pending    (mul_pending),
        .flag_stall     (flag_stall)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A flag-setting instruction must never reach EX while a multiply is pending.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mul_pending && ex_valid && ex_s_bit))
                else $error("[TB] illegal flag-setting EX instruction while multiply pending");
        end
    end

    function automatic vec_t mk(input logic v, input logic s, input logic m,
                                input logic [3:0] alu, input logic [3:0] mulf,
                                input logic needs, input logic sets,
                                input logic entry, input logic ret,
                                input logic chkOut, input logic [3:0] expOut,
                                input logic [3:0] expSaved, input logic expPend,
                                input logic expStall);
        vec_t r;
        r.v = v; r.s = s; r.m = m; r.alu = alu; r.mulf = mulf;
        r.needs = needs; r.sets = sets; r.entry = entry; r.ret = ret;
        r.chkOut = chkOut; r.expOut = expOut; r.expSaved = expSaved;
        r.expPend = expPend; r.expStall = expStall;
        return r;
    endfunction

    task automatic pushExp(input string name, input logic chkOut, input logic [3:0] out,
                           input logic [3:0] saved, input logic pend, input logic stall);
        exp_t e;
        e.name = name; e.chkOut = chkOut; e.out = out; e.saved = saved;
        e.pend = pend; e.stall = stall;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t t, input string name);
        ex_valid       = t.v;
        ex_s_bit       = t.s;
        ex_is_mul      = t.m;
        alu_flags      = t.alu;
        mul_flags      = t.mulf;
        id_needs_flags = t.needs;
        id_sets_flags  = t.sets;
        exc_entry      = t.entry;
        exc_return     = t.ret;
        pushExp(name, t.chkOut, t.expOut, t.expSaved, t.expPend, t.expStall);
    endtask

    task automatic checkOutput();
        exp_t e;
        numChecks++;
        if (sbq.size() == 0) begin
            numFails++;
            $display("[TB] FAIL scoreboard_empty got no expected entry, required one");
            return;
        end
        e = sbq.pop_front();
        if (e.chkOut) begin
            if (flags_out !== e.out) begin
                numFails++;
                $display("[TB] FAIL %s flags_out got %b required %b", e.name, flags_out, e.out);
            end
            numChecks++;
        end
        if (saved_flags !== e.saved) begin
            numFails++;
            $display("[TB] FAIL %s saved_flags got %b required %b", e.name, saved_flags, e.saved);
        end
        numChecks++;
        if (mul_pending !== e.pend) begin
            numFails++;
            $display("[TB] FAIL %s mul_pending got %b required %b", e.name, mul_pending, e.pend);
        end
        numChecks++;
        if (flag_stall !== e.stall) begin
            numFails++;
            $display("[TB] FAIL %s flag_stall got %b required %b", e.name, flag_stall, e.stall);
        end
    endtask

    task automatic idleInputs();
        ex_valid = 0; ex_s_bit = 0; ex_is_mul = 0; alu_flags = 4'b0000;
        mul_flags = 4'b0000; id_needs_flags = 0; id_sets_flags = 0;
        exc_entry = 0; exc_return = 0;
    endtask

    task automatic runVec(input vec_t t, input string name);
        applyStimulus(t, name);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();

        //      v s m  alu      mulf     nd st en rt  chk out      saved    pd sl
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b0000, 4'b0000, 0, 0)); // 0 idle
        vecs.push_back(mk(1,1,0, 4'b0100, 4'b0000, 1, 0, 0, 0,  1, 4'b0100, 4'b0000, 0, 0)); // 1 alu forward
        vecs.push_back(mk(0,0,0, 4'b1111, 4'b0000, 1, 0, 0, 0,  1, 4'b0100, 4'b0000, 0, 0)); // 2 committed
        vecs.push_back(mk(1,1,1, 4'b0000, 4'b0000, 1, 0, 0, 0,  1, 4'b0100, 4'b0000, 0, 0)); // 3 mul issue
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 1, 0, 0, 0,  1, 4'b0100, 4'b0000, 1, 1)); // 4 pend 1
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 1, 0, 0,  1, 4'b0100, 4'b0000, 1, 1)); // 5 pend 2
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b1001, 1, 0, 0, 0,  1, 4'b0100, 4'b0000, 1, 1)); // 6 pend 3
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 1, 0, 0, 0,  1, 4'b1001, 4'b0000, 0, 0)); // 7 mul visible
        vecs.push_back(mk(1,1,0, 4'b0011, 4'b0000, 0, 0, 0, 0,  1, 4'b0011, 4'b0000, 0, 0)); // 8 alu 0011
        vecs.push_back(mk(1,1,0, 4'b1100, 4'b0000, 0, 0, 1, 0,  0, 4'b0000, 4'b0000, 0, 0)); // 9 entry+alu
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b0011, 4'b0011, 0, 0)); // 10 squashed
        vecs.push_back(mk(1,1,0, 4'b1111, 4'b0000, 0, 0, 0, 0,  1, 4'b1111, 4'b0011, 0, 0)); // 11 alu 1111
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b1111, 4'b0011, 0, 0)); // 12
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 1,  1, 4'b1111, 4'b0011, 0, 0)); // 13 return
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b0011, 4'b0011, 0, 0)); // 14 restored
        vecs.push_back(mk(1,1,0, 4'b0110, 4'b0000, 0, 0, 0, 0,  1, 4'b0110, 4'b0011, 0, 0)); // 15 alu 0110
        vecs.push_back(mk(1,1,1, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b0110, 4'b0011, 0, 0)); // 16 mul issue
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b0110, 4'b0011, 1, 0)); // 17 no stall
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b1000, 0, 0, 1, 0,  1, 4'b0110, 4'b0011, 1, 0)); // 18 entry in pend
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b1000, 1, 0, 0, 0,  1, 4'b0110, 4'b0110, 0, 0)); // 19 aborted
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b1000, 1, 0, 0, 0,  1, 4'b0110, 4'b0110, 0, 0)); // 20 no late commit
        vecs.push_back(mk(1,1,0, 4'b1010, 4'b0000, 0, 0, 0, 0,  1, 4'b1010, 4'b0110, 0, 0)); // 21 alu 1010
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 1, 1,  1, 4'b1010, 4'b0110, 0, 0)); // 22 entry+return
        vecs.push_back(mk(0,0,0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 4'b1010, 4'b1010, 0, 0)); // 23 entry won

        @(negedge clk);
        pushExp("reset_state", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset with flags_q=1010 and an ALU write on the inputs.
        ex_valid = 1; ex_s_bit = 1; alu_flags = 4'b1111;
        #2;
        reset = 1'b1;
        #1;
        pushExp("async_reset", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        idleInputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset asserted while a multiply is pending must abandon it.
        runVec(mk(1,1,1, 4'b0000, 4'b0000, 1, 0, 0, 0,  1, 4'b0000, 4'b0000, 0, 0), "rst_pend_issue");
        runVec(mk(0,0,0, 4'b0000, 4'b1111, 1, 0, 0, 0,  1, 4'b0000, 4'b0000, 1, 1), "rst_pend_wait");
        mul_flags = 4'b1111;
        id_needs_flags = 1;
        #2;
        reset = 1'b1;
        #1;
        pushExp("rst_in_pend", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            runVec(mk(0,0,0, 4'b0000, 4'b1111, 1, 0, 0, 0,  1, 4'b0000, 4'b0000, 0, 0),
                   $sformatf("post_rst%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
